instruction_encoder: RTL and testbench
======================================

# instruction_encoder

Field-to-word MIPS instruction encoder and program loader: the write side of the instruction-field interface consumed by the instruction decoder. It accepts instruction fields over a valid/ready handshake, packs each into a 32-bit word by format (R, I, J), and writes the words to instruction memory at consecutive word addresses. It rejects opcodes outside the supported subset. It sits between the testbench/boot loader and the instruction memory.

## Interface
- ADDR_WIDTH, 10, instruction-memory word-address width
- BASE_ADDR, 0, first word address written after `start`
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a load session (honoured only in IDLE or DONE)
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_last  in  1  bundle is the final instruction of the session
- opcode  in  6  instruction[31:26]
- rs, rt, rd  in  5 each  register fields
- imm  in  16  I-type immediate
- addr  in  26  J-type target
- funct  in  6  R-type function
- mem_wr_en  out  1  write request, held until accepted
- mem_wr_addr  out  ADDR_WIDTH  word address
- mem_wr_data  out  32  encoded instruction
- mem_wr_ready  in  1  memory accepts write this cycle
- count  out  ADDR_WIDTH+1  words written this session
- busy  out  1  state is ACCEPT or WRITE
- done  out  1  level; session complete
- err_opcode  out  1  sticky; unsupported opcode seen
- err_full  out  1  sticky; instruction dropped because memory was full

## Operation
- Encoding:
  - R-type, opcode 000000: {opcode, rs, rt, rd, 5'b0, funct}.
  - J-type, opcode 000010 or 000011: {opcode, addr}.
  - I-type, opcodes 001000 addi, 000101 bne, 100011 lw, 101011 sw, 001110 xori: {opcode, rs, rt, imm}.
  - Fields not used by the format are ignored.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - On start: go to ACCEPT, write pointer=BASE_ADDR, count=0, err_opcode=0, err_full=0.
- ACCEPT:
  - in_ready=1. A handshake occurs when in_valid&in_ready.
  - Supported opcode, count<2^ADDR_WIDTH: latch word, pointer and in_last into the output buffer; go to WRITE.
  - Unsupported opcode: bundle is consumed and not written; err_opcode set; count unchanged.
  - Memory full (count==2^ADDR_WIDTH) with supported opcode: bundle is dropped; err_full set.
  - A dropped or rejected bundle with in_last set goes to DONE; otherwise the FSM stays in ACCEPT.
- WRITE:
  - in_ready=0. mem_wr_en=1; address and data are stable until accepted.
  - On mem_wr_ready: pointer+1 (wraps modulo 2^ADDR_WIDTH) and count+1.
  - Then go to DONE if the latched last flag is set, else to ACCEPT.
- DONE:
  - done=1; count and error flags hold.
  - start restarts the session, as from IDLE.
- start in ACCEPT or WRITE is ignored.
- reset_n low at any time, including mid-write: immediate return to IDLE.
- Reset values: every output is 0 (mem_wr_en, mem_wr_addr, mem_wr_data, count, busy, done, err_*, in_ready).

## Timing
- State, buffer and counters are registered. in_ready, busy and done decode from state only, with no combinational path from in_valid.
- Handshake at edge N: mem_wr_en=1 in cycle N+1 with the final address and data.
- Write accepted at edge M: in_ready=1 in cycle M+1, or done=1 in cycle M+1 if the write was the last.
- Sustained throughput with mem_wr_ready tied high: one instruction per 2 cycles.
- A rejected or dropped bundle costs 1 cycle and produces no write.
- start asserted at edge S: in_ready=1 in cycle S+1.

## Structure
- Shared package mips_isa_pkg holds:
  - opcode constants OP_RTYPE, OP_J, OP_JAL, OP_ADDI, OP_BNE, OP_LW, OP_SW, OP_XORI;
  - field bit-position constants;
  - the state enum typedef.
- The decoder also uses this package.
- Sub-module instruction_packer: combinational; fields in, 32-bit word and `supported` flag out. The FSM, buffer and counters live in instruction_encoder.

## Test plan
- Reset, then start, then addi rs=0 rt=8 imm=5 with in_last=1 and mem_wr_ready=1 -> mem_wr_data=0x20080005 at addr 0, count=1, done=1.
- R-type rs=9 rt=10 rd=8 funct=0x20, then j addr=0x10, then sw rs=29 rt=8 imm=4 (last) -> words 0x012A4020, 0x08000010 and 0xAFA80004 at addrs 0,1,2; count=3.
- Opcode 0x0F (lui) between two valid addi -> err_opcode=1, only 2 writes, addresses contiguous (0,1).
- Hold mem_wr_ready low 5 cycles during a write -> mem_wr_en, mem_wr_addr and mem_wr_data stable; in_ready=0 throughout; count increments once.
- ADDR_WIDTH=2, BASE_ADDR=3, 5 addi bundles -> addresses 3,0,1,2; fifth dropped with err_full=1; count=4.
- reset_n low while in WRITE -> all outputs 0 asynchronously, state IDLE; a following start gives a clean session from BASE_ADDR.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: MIPS subset opcodes, instruction field bit positions and encoder state enum shared by encoder and decoder
package mips_isa_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;
  localparam int ADDR_LSB  = 0;
  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_e;
endpackage

// File: rtl/instruction_packer.sv
// instruction_packer: combinational R/I/J packing of opcode, rs, rt, rd, imm, addr, funct into word, with supported flag
module instruction_packer
  import mips_isa_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] addr,
  input  logic [5:0]  funct,
  output logic [31:0] word,
  output logic        supported
);
  logic rtype, jtype, itype;
  always_comb begin
    rtype = opcode == OP_RTYPE;
    jtype = opcode == OP_J || opcode == OP_JAL;
    itype = opcode inside {OP_ADDI, OP_BNE, OP_LW, OP_SW, OP_XORI};
    supported = rtype | jtype | itype;
    word = rtype ? {opcode, rs, rt, rd, 5'b0, funct} :
           jtype ? {opcode, addr} :
           itype ? {opcode, rs, rt, imm} : 32'b0;
  end
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: valid/ready field bundles in, packed words written to consecutive memory addresses out, with count/done/error status
module instruction_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [5:0]            opcode,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [15:0]           imm,
  input  logic [25:0]           addr,
  input  logic [5:0]            funct,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [31:0]           mem_wr_data,
  input  logic                  mem_wr_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  err_opcode,
  output logic                  err_full
);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [31:0]           data_q, data_d, word;
  logic                  last_q, last_d, eop_q, eop_d, efull_q, efull_d, sup;
  instruction_packer u_packer (
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .addr(addr),
    .funct(funct), .word(word), .supported(sup)
  );
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    eop_d   = eop_q;
    efull_d = efull_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d = S_ACCEPT;
        ptr_d   = BASE;
        cnt_d   = '0;
        eop_d   = 1'b0;
        efull_d = 1'b0;
      end
      S_ACCEPT: if (in_valid) begin
        // count's top bit set means all 2^ADDR_WIDTH words are used
        if (sup && !cnt_q[ADDR_WIDTH]) begin
          addr_d  = ptr_q;
          data_d  = word;
          last_d  = in_last;
          state_d = S_WRITE;
        end else begin
          eop_d   = eop_q | !sup;
          efull_d = efull_q | sup;
          state_d = in_last ? S_DONE : S_ACCEPT;
        end
      end
      S_WRITE: if (mem_wr_ready) begin
        ptr_d   = ptr_q + 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = last_q ? S_DONE : S_ACCEPT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      eop_q   <= 1'b0;
      efull_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      eop_q   <= eop_d;
      efull_q <= efull_d;
    end
  end
  assign in_ready    = state_q == S_ACCEPT;
  assign mem_wr_en   = state_q == S_WRITE;
  assign busy        = in_ready | mem_wr_en;
  assign done        = state_q == S_DONE;
  assign mem_wr_addr = addr_q;
  assign mem_wr_data = data_q;
  assign count       = cnt_q;
  assign err_opcode  = eop_q;
  assign err_full    = efull_q;
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed checks of encoding, handshake, backpressure, wrap/full and async reset
module tb_instruction_encoder;
  logic        clk = 0, rst_n = 0, start = 0, start1 = 0, in_valid = 0, in_last = 0, mem_wr_ready = 1;
  logic [5:0]  opcode = 0, funct = 0;
  logic [4:0]  rs = 0, rt = 0, rd = 0;
  logic [15:0] imm = 0;
  logic [25:0] addr = 0;
  logic        in_ready, mem_wr_en, busy, done, err_opcode, err_full;
  logic [9:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [10:0] count;
  logic        in_ready1, mem_wr_en1, busy1, done1, err_opcode1, err_full1;
  logic [1:0]  mem_wr_addr1;
  logic [31:0] mem_wr_data1;
  logic [2:0]  count1;
  logic [31:0] qa0[$], qd0[$], qa1[$], qd1[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  instruction_encoder dut (
    .clk(clk), .reset_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .addr(addr),
    .funct(funct), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready), .count(count), .busy(busy), .done(done),
    .err_opcode(err_opcode), .err_full(err_full)
  );
  instruction_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(3)) dut1 (
    .clk(clk), .reset_n(rst_n), .start(start1), .in_valid(in_valid), .in_ready(in_ready1),
    .in_last(in_last), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .addr(addr),
    .funct(funct), .mem_wr_en(mem_wr_en1), .mem_wr_addr(mem_wr_addr1), .mem_wr_data(mem_wr_data1),
    .mem_wr_ready(mem_wr_ready), .count(count1), .busy(busy1), .done(done1),
    .err_opcode(err_opcode1), .err_full(err_full1)
  );
  always @(negedge clk) begin
    if (mem_wr_en && mem_wr_ready) begin
      qa0.push_back(32'(mem_wr_addr));
      qd0.push_back(mem_wr_data);
    end
    if (mem_wr_en1 && mem_wr_ready) begin
      qa1.push_back(32'(mem_wr_addr1));
      qd1.push_back(mem_wr_data1);
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input bit u);
    if (u) start1 = 1; else start = 1;
    step();
    start = 0;
    start1 = 0;
  endtask
  task automatic send(input bit u, input logic [5:0] op, input logic [4:0] s, t, d,
                      input logic [15:0] im, input logic [25:0] a, input logic [5:0] f, input logic l);
    bit ok = 0;
    opcode = op; rs = s; rt = t; rd = d; imm = im; addr = a; funct = f;
    in_valid = 1; in_last = l;
    for (int i = 0; i < 50; i++) begin
      if (u ? in_ready1 : in_ready) begin ok = 1; break; end
      step();
    end
    if (!ok) chk("hs_timeout", 0, 1);
    step();
    in_valid = 0; in_last = 0;
  endtask
  task automatic wait_done(input bit u, input string tag);
    for (int i = 0; i < 50; i++) begin
      if (u ? done1 : done) break;
      step();
    end
    chk(tag, u ? done1 : done, 1);
  endtask
  function automatic logic [63:0] outs0();
    return 64'({mem_wr_en, mem_wr_addr, mem_wr_data, count, busy, done, err_opcode, err_full, in_ready});
  endfunction
  initial begin
    #2;
    chk("reset_outs", outs0(), 0);
    step();
    rst_n = 1;
    step();
    chk("idle_ready", in_ready, 0);
    go(0);
    chk("start_ready", in_ready, 1);
    chk("start_busy", busy, 1);
    send(0, 6'h08, 5'd0, 5'd8, 5'd0, 16'h0005, 26'h0, 6'h0, 1);
    chk("t1_en", mem_wr_en, 1);
    chk("t1_addr_early", mem_wr_addr, 0);
    chk("t1_data_early", mem_wr_data, 32'h20080005);
    wait_done(0, "t1_done");
    chk("t1_nwr", qa0.size(), 1);
    chk("t1_addr", qa0[0], 0);
    chk("t1_data", qd0[0], 32'h20080005);
    chk("t1_count", count, 1);
    chk("t1_busy", busy, 0);
    qa0.delete(); qd0.delete();
    go(0);
    send(0, 6'h00, 5'd9, 5'd10, 5'd8, 16'hFFFF, 26'h3FFFFFF, 6'h20, 0);
    send(0, 6'h02, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h10, 6'h3F, 0);
    send(0, 6'h2B, 5'd29, 5'd8, 5'd31, 16'h0004, 26'h3FFFFFF, 6'h3F, 1);
    wait_done(0, "t2_done");
    chk("t2_nwr", qa0.size(), 3);
    if (qa0.size() == 3) begin
      chk("t2_a0", qa0[0], 0);
      chk("t2_a1", qa0[1], 1);
      chk("t2_a2", qa0[2], 2);
      chk("t2_d0", qd0[0], 32'h012A4020);
      chk("t2_d1", qd0[1], 32'h08000010);
      chk("t2_d2", qd0[2], 32'hAFA80004);
    end
    chk("t2_count", count, 3);
    chk("t2_errop", err_opcode, 0);
    qa0.delete(); qd0.delete();
    go(0);
    send(0, 6'h08, 5'd1, 5'd2, 5'd0, 16'h1234, 26'h0, 6'h0, 0);
    send(0, 6'h0F, 5'd1, 5'd2, 5'd0, 16'h5555, 26'h0, 6'h0, 0);
    send(0, 6'h08, 5'd3, 5'd4, 5'd0, 16'hFFFF, 26'h0, 6'h0, 1);
    wait_done(0, "t3_done");
    chk("t3_errop", err_opcode, 1);
    chk("t3_errfull", err_full, 0);
    chk("t3_nwr", qa0.size(), 2);
    if (qa0.size() == 2) begin
      chk("t3_a0", qa0[0], 0);
      chk("t3_a1", qa0[1], 1);
      chk("t3_d0", qd0[0], 32'h20221234);
      chk("t3_d1", qd0[1], 32'h2064FFFF);
    end
    chk("t3_count", count, 2);
    qa0.delete(); qd0.delete();
    mem_wr_ready = 0;
    go(0);
    chk("t4_errop_clr", err_opcode, 0);
    send(0, 6'h08, 5'd0, 5'd8, 5'd0, 16'h0005, 26'h0, 6'h0, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_en", mem_wr_en, 1);
      chk("t4_addr", mem_wr_addr, 0);
      chk("t4_data", mem_wr_data, 32'h20080005);
      chk("t4_ready", in_ready, 0);
      chk("t4_count", count, 0);
      step();
    end
    mem_wr_ready = 1;
    wait_done(0, "t4_done");
    chk("t4_nwr", qa0.size(), 1);
    chk("t4_count_end", count, 1);
    go(1);
    for (int k = 1; k <= 5; k++)
      send(1, 6'h08, 5'd0, 5'(k), 5'd0, 16'(k), 26'h0, 6'h0, k == 5);
    wait_done(1, "t5_done");
    chk("t5_nwr", qa1.size(), 4);
    if (qa1.size() == 4) begin
      chk("t5_a0", qa1[0], 3);
      chk("t5_a1", qa1[1], 0);
      chk("t5_a2", qa1[2], 1);
      chk("t5_a3", qa1[3], 2);
      chk("t5_d0", qd1[0], 32'h20010001);
      chk("t5_d3", qd1[3], 32'h20040004);
    end
    chk("t5_errfull", err_full1, 1);
    chk("t5_errop", err_opcode1, 0);
    chk("t5_count", count1, 4);
    qa0.delete(); qd0.delete();
    mem_wr_ready = 0;
    go(0);
    send(0, 6'h00, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 6'h21, 0);
    chk("t6_inwrite", mem_wr_en, 1);
    #2 rst_n = 0;
    #1 chk("t6_async_outs", outs0(), 0);
    step();
    rst_n = 1;
    mem_wr_ready = 1;
    step();
    chk("t6_idle_outs", outs0(), 0);
    go(0);
    send(0, 6'h08, 5'd0, 5'd8, 5'd0, 16'h0005, 26'h0, 6'h0, 1);
    wait_done(0, "t6_done");
    chk("t6_nwr", qa0.size(), 1);
    if (qa0.size() == 1) begin
      chk("t6_addr", qa0[0], 0);
      chk("t6_data", qd0[0], 32'h20080005);
    end
    chk("t6_count", count, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
